// File: rtl/serializer.sv
// Parallel-in, serial-out shifter with busy/done status.
// A load restarts the word from scratch, even when a word is still shifting out.
module serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] par_data,
  input  logic             load,
  output logic             ser_o,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sreg_shift;

  // The bit currently on the line always sits at the exit end of sreg.
  generate
    if (MSB_FIRST) begin : g_msb
      assign sreg_shift = {sreg[WIDTH-2:0], 1'b0};
      assign ser_o      = busy & sreg[WIDTH-1];
    end else begin : g_lsb
      assign sreg_shift = {1'b0, sreg[WIDTH-1:1]};
      assign ser_o      = busy & sreg[0];
    end
  endgenerate

  assign busy = (cnt != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sreg <= '0;
      cnt  <= '0;
      done <= 1'b0;
    end else if (load) begin
      sreg <= par_data;
      cnt  <= CW'(WIDTH);
      done <= 1'b0;
    end else if (busy) begin
      sreg <= sreg_shift;
      cnt  <= cnt - CW'(1);
      done <= (cnt == CW'(1));
    end else begin
      done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_serializer.sv
// Scoreboard bench: an 8-bit MSB-first and a 4-bit LSB-first serializer share the clock and reset.
// Each queue entry is the expected {ser_o, busy, done} just after one rising edge.
module tb_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] par8;
  logic       load8;
  logic       ser8, busy8, done8;
  logic [3:0] par4;
  logic       load4;
  logic       ser4, busy4, done4;

  logic [2:0] q8[$];
  logic [2:0] q4[$];
  int n_chk = 0;
  int n_err = 0;

  serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_w8 (
    .clk(clk), .rst(rst), .par_data(par8), .load(load8),
    .ser_o(ser8), .busy(busy8), .done(done8)
  );

  serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) u_w4 (
    .clk(clk), .rst(rst), .par_data(par4), .load(load4),
    .ser_o(ser4), .busy(busy4), .done(done4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [2:0] got, input logic [2:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got {ser,busy,done}=%b expected %b", tag, got, exp);
    end
  endtask

  task automatic push_st(input bit sel, input logic [2:0] v);
    if (sel) q4.push_back(v);
    else     q8.push_back(v);
  endtask

  // Expected line state for a whole word: one bit per edge, busy high, no done.
  task automatic push_word(input bit sel, input logic [31:0] d, input int w, input bit msb);
    logic b;
    for (int i = 0; i < w; i++) begin
      b = msb ? d[w-1-i] : d[i];
      push_st(sel, {b, 2'b10});
    end
  endtask

  // An empty queue means that instance is expected to sit idle.
  task automatic tick(input string tag);
    logic [2:0] e8, e4;
    @(posedge clk);
    #1;
    e8 = (q8.size() != 0) ? q8.pop_front() : 3'b000;
    e4 = (q4.size() != 0) ? q4.pop_front() : 3'b000;
    chk({tag, "_w8"}, {ser8, busy8, done8}, e8);
    chk({tag, "_w4"}, {ser4, busy4, done4}, e4);
  endtask

  initial begin
    rst = 1'b0; load8 = 1'b1; par8 = 8'hFF; load4 = 1'b1; par4 = 4'hF;
    repeat (3) tick("reset");
    rst = 1'b1; load8 = 1'b0; load4 = 1'b0;
    tick("idle");

    // Basic MSB-first, par_data noise while shifting
    push_st(0, 3'b010);
    load8 = 1'b1; par8 = 8'h00;
    tick("basic_ld0");
    push_word(0, 32'hA6, 8, 1'b1);
    push_st(0, 3'b001);
    push_st(0, 3'b000);
    par8 = 8'hA6;
    tick("basic");
    load8 = 1'b0;
    repeat (7) begin
      par8 = 8'($urandom);
      tick("basic");
    end
    repeat (2) tick("basic_end");

    // Load held for five edges
    repeat (4) push_st(0, 3'b110);
    push_word(0, 32'hA5, 8, 1'b1);
    push_st(0, 3'b001);
    push_st(0, 3'b000);
    load8 = 1'b1; par8 = 8'hA5;
    repeat (5) tick("held");
    load8 = 1'b0;
    repeat (9) tick("held");

    // Restart mid-word
    repeat (3) push_st(0, 3'b110);
    push_word(0, 32'h0F, 8, 1'b1);
    push_st(0, 3'b001);
    push_st(0, 3'b000);
    load8 = 1'b1; par8 = 8'hF0;
    tick("restart");
    load8 = 1'b0;
    repeat (2) tick("restart");
    load8 = 1'b1; par8 = 8'h0F;
    tick("restart");
    load8 = 1'b0;
    repeat (9) tick("restart");

    // Back-to-back: reload on the edge where done would rise
    push_word(0, 32'h81, 8, 1'b1);
    push_word(0, 32'h7E, 8, 1'b1);
    push_st(0, 3'b001);
    push_st(0, 3'b000);
    load8 = 1'b1; par8 = 8'h81;
    tick("b2b");
    load8 = 1'b0;
    repeat (7) tick("b2b");
    load8 = 1'b1; par8 = 8'h7E;
    tick("b2b");
    load8 = 1'b0;
    repeat (9) tick("b2b");

    // LSB-first, 4 bits
    push_word(1, 32'h3, 4, 1'b0);
    push_st(1, 3'b001);
    push_st(1, 3'b000);
    load4 = 1'b1; par4 = 4'b0011;
    tick("lsb");
    load4 = 1'b0;
    repeat (5) tick("lsb");

    // Asynchronous reset in the middle of a word
    load8 = 1'b1; par8 = 8'hFF;
    push_word(0, 32'hFF, 8, 1'b1);
    tick("rst_mid");
    load8 = 1'b0;
    repeat (2) tick("rst_mid");
    #2;
    rst = 1'b0;
    #1;
    chk("rst_async", {ser8, busy8, done8}, 3'b000);
    q8.delete();
    load8 = 1'b1;
    repeat (2) tick("rst_hold");
    rst = 1'b1; load8 = 1'b0;
    tick("rst_rel");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/serializer.md
Name: serializer

Overview:
- Parallel-in, serial-out converter: captures a WIDTH-bit word on a load strobe and shifts it out one bit per clock on ser_o.
- Sits between a parallel datapath and a single-wire serial link.
- Provides busy/done status so an upstream controller can pace loads.

Parameters:
- WIDTH, 8, parallel word width in bits; legal range 2..32.
- MSB_FIRST, 1, 1 = transmit bit WIDTH-1 first; 0 = transmit bit 0 first.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- par_data  input  WIDTH  parallel word to serialize, sampled on load.
- load  input  1  load strobe, sampled on rising clk.
- ser_o  output  1  serial data out.
- busy  output  1  high while a word is being shifted out.
- done  output  1  one-cycle pulse after the last bit of a word.
- Port order is clk, rst, par_data, load, ser_o, busy, done. busy and done are trailing ports and may be left unconnected.

Behaviour:
- Reset (rst=0, asynchronous, immediate):
  - Shift register = 0, bit counter = 0, busy = 0, done = 0, ser_o = 0.
  - load is ignored while rst=0.
- State: shift register sreg[WIDTH-1:0] and counter cnt (width clog2(WIDTH+1)).
  - busy = (cnt != 0).
- ser_o:
  - Combinational from registered state only; no path from inputs.
  - When busy: sreg[WIDTH-1] if MSB_FIRST, else sreg[0].
  - When idle: 0.
- Load (rising edge with load=1):
  - sreg <= par_data, cnt <= WIDTH, done <= 0.
  - The first bit appears on ser_o right after this edge (zero-cycle latency from load edge).
  - load has priority over shifting: asserting load while busy aborts the current word and restarts with the new par_data.
  - load held high for N edges reloads on every edge; shifting starts on the first edge with load=0.
- Shift (rising edge, load=0, busy):
  - MSB_FIRST=1: sreg <= {sreg[WIDTH-2:0],1'b0}.
  - MSB_FIRST=0: sreg <= {1'b0,sreg[WIDTH-1:1]}.
  - cnt <= cnt-1.
  - When cnt goes 1->0: busy drops and done <= 1 for exactly one cycle.
- Idle (load=0, cnt=0): registers hold, done <= 0, ser_o = 0.
- Timing of one word: each bit is valid for exactly one clock period. Bits occupy the load edge plus the next WIDTH-1 edges. busy is high for exactly WIDTH cycles, and done is asserted on the following edge.
- Back-to-back: load asserted on the same edge that done would rise means the reload wins. done stays 0 and busy stays 1.
- par_data changes while not loading have no effect.

Test Plan:
- Reset: rst=0 with load=1 and par_data=8'hFF, clocks running -> ser_o=0, busy=0, done=0 throughout. rst=0 asserted mid-word -> all outputs 0 immediately, before the next edge.
- Basic MSB-first: load high over two edges with par_data=0 then 8'b10100110, then low -> ser_o = 1,0,1,0,0,1,1,0 on successive cycles starting at the last load edge. busy high 8 cycles, then done=1 for one cycle, then ser_o=0.
- Load held high: load=1 for 5 edges with par_data=8'hA5 -> ser_o stays 1 (reload each edge). Then 8'hA5 shifts out, ending with done pulse.
- Restart mid-word: load 8'hF0, after 3 bits (1,1,1) load 8'h0F -> sequence continues 0,0,0,0,1,1,1,1. Exactly one done pulse.
- Back-to-back words: 8'h81 then load 8'h7E on the edge after the last bit -> 16 contiguous bits 10000001 01111110 with no idle gap. busy continuous, done only after the second word.
- LSB-first (MSB_FIRST=0, WIDTH=4): load 4'b0011 -> ser_o = 1,1,0,0, then done.
